regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
  - DATA_WIDTH, 32, register width in bits.
  - ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
  - NUM_READ, 2, number of independent read ports.
  - BYPASS, 1, 1 = same-cycle write data forwarded to read ports.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
  - clk, in, 1, single clock; all state updates on rising edge.
  - rst_n, in, 1, asynchronous active-low reset.
  - rd_addr, in, NUM_READ*ADDR_WIDTH, packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
  - rd_data, out, NUM_READ*DATA_WIDTH, packed read data, same packing.
  - rd_busy, out, NUM_READ, scoreboard busy bit of each read address.
  - wr0_en / wr0_addr / wr0_data, in, 1 / ADDR_WIDTH / DATA_WIDTH, write port 0, higher priority.
  - wr1_en / wr1_addr / wr1_data, in, 1 / ADDR_WIDTH / DATA_WIDTH, write port 1.
  - iss_en / iss_addr, in, 1 / ADDR_WIDTH, mark destination register pending.
  - init_done, out, 1, high once post-reset clearing completes.
REQ-003 The clock port SHALL be named clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]] with zero cycles of latency.
REQ-005 Register 0 SHALL read as 0 on every port; writes and issues to address 0 SHALL be ignored; busy[0] SHALL be constant 0.
REQ-006 Writes SHALL commit on the rising edge of clk when wrN_en=1 and init_done=1.
REQ-007 If both write ports target the same nonzero address in one cycle, wr0_data SHALL be stored and wr1 SHALL be dropped.
REQ-008 With BYPASS=1, a read of an address written in the current cycle SHALL return the winning write data, using the REQ-007 priority; with BYPASS=0 it SHALL return the pre-edge contents.
REQ-009 Scoreboard: iss_en=1 SHALL set busy[iss_addr] at the edge; an enabled write SHALL clear busy[wr_addr] at the edge.
REQ-010 Simultaneous issue and write to the same address SHALL leave busy=1 (set wins).
REQ-011 rd_busy[i] SHALL equal busy[rd_addr[i]]; with BYPASS=1 it SHALL read 0 when a write to that address is in progress this cycle and no same-cycle issue targets it.
REQ-012 Init sequencer: after rst_n rises, edge k (k = 1..2**ADDR_WIDTH) SHALL clear register k-1; init_done SHALL rise on edge 2**ADDR_WIDTH.
REQ-013 While init_done=0: rd_data SHALL be 0, rd_busy SHALL be 0, and all writes and issues SHALL be ignored.
REQ-014 The init counter SHALL not wrap; after completion it SHALL hold until the next reset.

Reset
REQ-015 rst_n low SHALL immediately force init_done=0, the init counter to 0 and all busy bits to 0, independent of clk.
REQ-016 Register contents SHALL not be reset asynchronously; they are cleared only by the REQ-012 sequence.
REQ-017 Reset asserted mid-sequence or mid-operation SHALL restart the full clearing sequence from register 0.

Structure
REQ-018 Shared package regfile_pkg SHALL hold the default DATA_WIDTH and ADDR_WIDTH constants and the init-state encoding (INIT_CLEAR, INIT_DONE).
REQ-019 The clearing counter and FSM SHALL be one sub-module, regfile_init_seq (outputs: clear_en, clear_addr, init_done).
REQ-020 Storage SHALL be a single register array; read ports SHALL be generated NUM_READ times.

Verification
REQ-021 Reset release, then 32 cycles idle -> init_done=0 through edge 31, 1 at edge 32; all 32 registers read 0.
REQ-022 Write wr0 x5=0xDEADBEEF, and in the same cycle read x5 on port 1 -> BYPASS=1: 0xDEADBEEF the same cycle; BYPASS=0: 0 that cycle, 0xDEADBEEF the next.
REQ-023 wr0 x7=0x11 and wr1 x7=0x22 in the same cycle; wr1 x0=0xFF -> x7 reads 0x11; x0 reads 0.
REQ-024 Issue x3, then two cycles later write x3=0x55 together with a new issue of x3 -> rd_busy=1 after the first edge, and stays 1 after the write edge; data reads 0x55.
REQ-025 Assert rst_n low at edge 10 of init, release -> busy is cleared, init_done=0, and all 32 clearing edges repeat; a write during init is ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose: shared defaults and init-sequencer state encoding for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // INIT_CLEAR walks every register to zero after reset; INIT_DONE is the
    // normal operating state and is held until the next reset.
    typedef enum logic {
        INIT_CLEAR = 1'b0,
        INIT_DONE  = 1'b1
    } init_state_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Purpose: post-reset clearing sequencer; emits one clear per clock for addresses 0..2**ADDR_WIDTH-1.
// Latency: init_done rises on the 2**ADDR_WIDTH-th rising edge after rst_n is released.
// Backpressure: none; runs free and cannot be stalled.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (restarts the sequence)
//   clear_en    - high while the sequencer is clearing; clear_addr is valid
//   clear_addr  - register being cleared on the coming edge
//   init_done   - high once every register has been cleared
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clear_en,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_done
);

    init_state_e           r_state;
    init_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter stops on the last address rather than wrapping, so it
    // simply holds its final value while in INIT_DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clear_en    = 1'b0;
        init_done   = 1'b0;
        case (r_state)
            INIT_CLEAR: begin
                clear_en = 1'b1;
                if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = INIT_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            INIT_DONE: begin
                init_done = 1'b1;
            end
        endcase
    end

    assign clear_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Purpose: multi-read, dual-write register file with a per-register busy scoreboard and x0 hardwired to zero.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates commit on the rising edge.
// Backpressure: none; all writes/issues are accepted once init_done is high and ignored before that.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   rd_addr / rd_data   - NUM_READ packed read ports, port i at [i*W +: W]
//   rd_busy             - scoreboard busy bit of each read address
//   wr0_* / wr1_*       - write ports; wr0 wins on an address collision
//   iss_en / iss_addr   - marks a destination register pending
//   init_done           - high once post-reset clearing has finished
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr0_en,
    input  logic [ADDR_WIDTH-1:0]          wr0_addr,
    input  logic [DATA_WIDTH-1:0]          wr0_data,
    input  logic                           wr1_en,
    input  logic [ADDR_WIDTH-1:0]          wr1_addr,
    input  logic [DATA_WIDTH-1:0]          wr1_data,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    output logic                           init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic                  w_clear_en;
    logic [ADDR_WIDTH-1:0] w_clear_addr;
    logic                  w_wr0_act;
    logic                  w_wr1_act;
    logic                  w_iss_act;

    regfile_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_en   (w_clear_en),
        .clear_addr (w_clear_addr),
        .init_done  (init_done)
    );

    // Qualified requests: nothing lands before init completes, and x0 is
    // never a legal target for a write or an issue.
    assign w_wr0_act = init_done && wr0_en && (wr0_addr != '0);
    assign w_wr1_act = init_done && wr1_en && (wr1_addr != '0);
    assign w_iss_act = init_done && iss_en && (iss_addr != '0);

    // Storage has no reset; contents are zeroed only by the init sequencer.
    // wr0 is assigned last so it overrides wr1 on a collision.
    always_ff @(posedge clk) begin
        if (w_clear_en) begin
            r_mem[w_clear_addr] <= '0;
        end else begin
            if (w_wr1_act) begin
                r_mem[wr1_addr] <= wr1_data;
            end
            if (w_wr0_act) begin
                r_mem[wr0_addr] <= wr0_data;
            end
        end
    end

    // Scoreboard: issue sets, write clears, and a same-edge issue beats the
    // write so a newly issued producer is never lost. Bit 0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int j = 1; j < DEPTH; j++) begin
                if (w_iss_act && (iss_addr == ADDR_WIDTH'(j))) begin
                    r_busy[j] <= 1'b1;
                end else if ((w_wr0_act && (wr0_addr == ADDR_WIDTH'(j))) ||
                             (w_wr1_act && (wr1_addr == ADDR_WIDTH'(j)))) begin
                    r_busy[j] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_hit0;
        logic                  w_hit1;
        logic                  w_iss_hit;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_bsy;

        assign w_addr    = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hit0    = w_wr0_act && (wr0_addr == w_addr);
        assign w_hit1    = w_wr1_act && (wr1_addr == w_addr);
        assign w_iss_hit = w_iss_act && (iss_addr == w_addr);

        always_comb begin
            w_data = r_mem[w_addr];
            w_bsy  = r_busy[w_addr];
            if (BYPASS != 0) begin
                // Forward the write that will actually win at the edge.
                if (w_hit0) begin
                    w_data = wr0_data;
                end else if (w_hit1) begin
                    w_data = wr1_data;
                end
                // A completing write releases the register early unless a
                // new issue is re-claiming it on the same edge.
                if ((w_hit0 || w_hit1) && !w_iss_hit) begin
                    w_bsy = 1'b0;
                end
            end
            if (!init_done || (w_addr == '0)) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rd_busy[i]                          = w_bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose: directed table-driven bench for regfile_mp, with BYPASS=1 and BYPASS=0 instances on shared stimulus.
// Latency: checks combinational outputs before each edge and registered state after it.
// Backpressure: n/a.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        wr0_en, wr1_en, iss_en;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        init_done_b, init_done_n;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .init_done(init_done_b)
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .init_done(init_done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] bd0;   // BYPASS=1 expected rd_data port 0 / 1 / busy {p1,p0}
        logic [31:0] bd1;
        logic [1:0]  bb;
        logic [31:0] nd0;   // BYPASS=0 expected rd_data port 0 / 1 / busy {p1,p0}
        logic [31:0] nd1;
        logic [1:0]  nb;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic ie, input logic [4:0] ia,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] bd0, input logic [31:0] bd1, input logic [1:0] bb,
        input logic [31:0] nd0, input logic [31:0] nd1, input logic [1:0] nb);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie  = ie;  v.ia  = ia;
        v.ra0 = ra0; v.ra1 = ra1;
        v.bd0 = bd0; v.bd1 = bd1; v.bb = bb;
        v.nd0 = nd0; v.nd1 = nd1; v.nb = nb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_addr = v.ia;
        rd_addr = {v.ra1, v.ra0};
    endtask

    initial begin
        idle_inputs();
        rd_addr = '0;
        rst_n   = 1'b0;

        // Directed vectors, one per cycle, starting from a freshly cleared file.
        tv.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0, 5,  0, 32'hDEADBEEF, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
        tv.push_back(mk(1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 0, 32'h11, 0, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            1, 0, 32'hFF, 0, 0, 7, 0, 32'h11, 0, 2'b00,  32'h11, 0, 2'b00));
        tv.push_back(mk(1, 10, 32'h1010,    1, 9, 32'h99, 0, 0, 9, 10, 32'h99, 32'h1010, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 9, 10, 32'h99, 32'h1010, 2'b00,  32'h99, 32'h1010, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     1, 3, 3, 0,  0, 0, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 3, 3,  0, 0, 2'b11,  0, 0, 2'b11));
        tv.push_back(mk(1, 3, 32'h55,       0, 0, 0,     1, 3, 3, 3,  32'h55, 32'h55, 2'b11,  0, 0, 2'b11));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 3, 3,  32'h55, 32'h55, 2'b11,  32'h55, 32'h55, 2'b11));
        tv.push_back(mk(0, 0, 0,            1, 3, 32'h66, 0, 0, 3, 5, 32'h66, 32'hDEADBEEF, 2'b00,  32'h55, 32'hDEADBEEF, 2'b01));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 3, 7,  32'h66, 32'h11, 2'b00,  32'h66, 32'h11, 2'b00));
        tv.push_back(mk(1, 0, 32'h123,      0, 0, 0,     1, 0, 0, 0,  0, 0, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 7,  0, 32'h11, 2'b00,  0, 32'h11, 2'b00));
        tv.push_back(mk(1, 6, 32'h77,       1, 6, 32'h66, 1, 4, 6, 4, 32'h77, 0, 2'b00,  0, 0, 2'b00));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 6, 4,  32'h77, 0, 2'b10,  32'h77, 0, 2'b10));
        tv.push_back(mk(1, 4, 32'h44,       0, 0, 0,     0, 0, 4, 4,  32'h44, 32'h44, 2'b00,  0, 0, 2'b11));
        tv.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 0,  32'h44, 0, 2'b00,  32'h44, 0, 2'b00));

        // Reset state.
        #2;
        chk("rst_init_done_b", 32'(init_done_b), 32'h0);
        chk("rst_init_done_n", 32'(init_done_n), 32'h0);
        chk("rst_busy_b", 32'(rd_busy_b), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rel_init_done_b", 32'(init_done_b), 32'h0);

        // Clearing sequence: init_done low through edge 31, high at edge 32.
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("init1_done_b_e%0d", k), 32'(init_done_b), (k == 32) ? 32'h1 : 32'h0);
            chk($sformatf("init1_done_n_e%0d", k), 32'(init_done_n), (k == 32) ? 32'h1 : 32'h0);
        end

        // Every register reads zero after clearing.
        for (int j = 0; j < 32; j++) begin
            rd_addr = {5'(31 - j), 5'(j)};
            #1;
            chk($sformatf("clr_b_x%0d", j), rd_data_b[31:0], 32'h0);
            chk($sformatf("clr_n_x%0d", j), rd_data_n[63:32], 32'h0);
        end

        // Table: drive, check combinational outputs pre-edge, take the edge.
        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i]);
            #1;
            chk($sformatf("v%0d_bd0", i), rd_data_b[31:0],  tv[i].bd0);
            chk($sformatf("v%0d_bd1", i), rd_data_b[63:32], tv[i].bd1);
            chk($sformatf("v%0d_bb", i),  32'(rd_busy_b),   32'(tv[i].bb));
            chk($sformatf("v%0d_nd0", i), rd_data_n[31:0],  tv[i].nd0);
            chk($sformatf("v%0d_nd1", i), rd_data_n[63:32], tv[i].nd1);
            chk($sformatf("v%0d_nb", i),  32'(rd_busy_n),   32'(tv[i].nb));
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Mid-operation reset: pending busy bit must clear immediately.
        iss_en = 1'b1; iss_addr = 5'd8;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_addr = {5'd8, 5'd8};
        #1;
        chk("pre_rst_busy8", 32'(rd_busy_n), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_done_b", 32'(init_done_b), 32'h0);
        chk("async_rst_busy_n", 32'(rd_busy_n), 32'h0);
        chk("async_rst_busy_int", 32'(u_nb.r_busy[8]), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Abort the clearing sequence at edge 10.
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_init_done_b", 32'(init_done_b), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done_b", 32'(init_done_b), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Full restart with writes/issues held active throughout; all ignored.
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hABC;
        wr1_en = 1'b1; wr1_addr = 5'd13; wr1_data = 32'hBCD;
        iss_en = 1'b1; iss_addr = 5'd14;
        rd_addr = {5'd14, 5'd10};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("init2_done_b_e%0d", k), 32'(init_done_b), (k == 32) ? 32'h1 : 32'h0);
            chk($sformatf("init2_rd_b_e%0d", k), rd_data_b[31:0], 32'h0);
            chk($sformatf("init2_busy_n_e%0d", k), 32'(rd_busy_n), 32'h0);
        end
        idle_inputs();

        rd_addr = {5'd13, 5'd12};
        #1;
        chk("ign_wr0_x12", rd_data_n[31:0],  32'h0);
        chk("ign_wr1_x13", rd_data_n[63:32], 32'h0);
        rd_addr = {5'd8, 5'd14};
        #1;
        chk("ign_iss_x14", 32'(rd_busy_n), 32'h0);
        rd_addr = {5'd9, 5'd10};
        #1;
        chk("reclr_x10", rd_data_n[31:0],  32'h0);
        chk("reclr_x9",  rd_data_n[63:32], 32'h0);

        // Writes are accepted again after the restart.
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'hCAFE;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("post_wr_x10", rd_data_n[31:0], 32'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
